// File: rtl/mdu_sequencer_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide sequencer.
// The EX stage drives the master side and the sequencer implements the slave side.
interface mdu_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              i_con_Start;
  logic [5:0]        i_con_FuncCode;
  logic              i_con_Abort;
  logic [DATA_W-1:0] i_dat_Rs;
  logic [DATA_W-1:0] i_dat_Rt;
  logic              o_con_Busy;
  logic              o_con_Stall;
  logic              o_con_Done;
  logic [DATA_W-1:0] o_dat_Hi;
  logic [DATA_W-1:0] o_dat_Lo;
  logic [DATA_W-1:0] o_dat_MfData;

  modport master (
    output i_con_Start, i_con_FuncCode, i_con_Abort, i_dat_Rs, i_dat_Rt,
    input  o_con_Busy, o_con_Stall, o_con_Done, o_dat_Hi, o_dat_Lo, o_dat_MfData
  );

  modport slave (
    input  i_con_Start, i_con_FuncCode, i_con_Abort, i_dat_Rs, i_dat_Rt,
    output o_con_Busy, o_con_Stall, o_con_Done, o_dat_Hi, o_dat_Lo, o_dat_MfData
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit that owns HI/LO. It does one shift-add or restoring
// step per cycle, then applies sign correction in a final FIX cycle.
//
//   state | meaning
//   IDLE  | accepts mult/multu/div/divu; mthi/mtlo write HI/LO directly
//   RUN   | one multiplier or quotient bit per cycle, DATA_W cycles
//   FIX   | sign correction, HI/LO written on exit, Done follows
module mdu_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mdu_sequencer_if.slave  bus
);
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   rs_q, rs_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic [5:0]          funct;
  logic                is_iter, is_mdu, is_sgn, sa, sb;
  logic [DATA_W-1:0]   mag_rs, mag_rt;
  logic [DATA_W:0]     msum;
  logic [2*DATA_W-1:0] mstep;
  logic [DATA_W:0]     rsh, dsub;
  logic                qbit;
  logic [2*DATA_W-1:0] dstep;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix, fix_hi, fix_lo;
  logic [2*DATA_W-1:0] prod_fix;
  logic                div0;

  assign funct   = bus.i_con_FuncCode;
  assign is_iter = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
  assign is_mdu  = is_iter || (funct == F_MFHI) || (funct == F_MTHI) ||
                   (funct == F_MFLO) || (funct == F_MTLO);
  assign is_sgn  = (funct == F_MULT) || (funct == F_DIV);
  assign sa      = is_sgn & bus.i_dat_Rs[DATA_W-1];
  assign sb      = is_sgn & bus.i_dat_Rt[DATA_W-1];
  assign mag_rs  = sa ? -bus.i_dat_Rs : bus.i_dat_Rs;
  assign mag_rt  = sb ? -bus.i_dat_Rt : bus.i_dat_Rt;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign msum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                 {1'b0, (acc_q[0] ? op_q : {DATA_W{1'b0}})};
  assign mstep = {msum, acc_q[DATA_W-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
  assign rsh   = acc_q[2*DATA_W-1:DATA_W-1];
  assign dsub  = rsh - {1'b0, op_q};
  assign qbit  = ~dsub[DATA_W];
  assign dstep = {(qbit ? dsub[DATA_W-1:0] : rsh[DATA_W-1:0]), acc_q[DATA_W-2:0], qbit};

  assign quo      = acc_q[DATA_W-1:0];
  assign rem      = acc_q[2*DATA_W-1:DATA_W];
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = rneg_q ? -rem : rem;
  assign div0     = (op_q == {DATA_W{1'b0}});
  assign fix_hi   = is_div_q ? (div0 ? rs_q : rem_fix) : prod_fix[2*DATA_W-1:DATA_W];
  assign fix_lo   = is_div_q ? (div0 ? {DATA_W{1'b1}} : quo_fix) : prod_fix[DATA_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rs_q     <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rs_d     = rs_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A flushed instruction must not commit anything, including mthi/mtlo.
        if (bus.i_con_Start && !bus.i_con_Abort) begin
          if (is_iter) begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = funct[1];
            neg_d    = sa ^ sb;
            rneg_d   = sa;
            rs_d     = bus.i_dat_Rs;
            op_d     = funct[1] ? mag_rt : mag_rs;
            acc_d    = {{DATA_W{1'b0}}, (funct[1] ? mag_rs : mag_rt)};
          end else if (funct == F_MTHI) begin
            hi_d = bus.i_dat_Rs;
          end else if (funct == F_MTLO) begin
            lo_d = bus.i_dat_Rs;
          end
        end
      end
      RUN: begin
        if (bus.i_con_Abort) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? dstep : mstep;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.i_con_Abort) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_con_Busy   = (state_q != IDLE);
  assign bus.o_con_Stall  = bus.o_con_Busy & bus.i_con_Start & is_mdu;
  assign bus.o_con_Done   = done_q;
  assign bus.o_dat_Hi     = hi_q;
  assign bus.o_dat_Lo     = lo_q;
  assign bus.o_dat_MfData = (funct == F_MFHI) ? hi_q :
                            (funct == F_MFLO) ? lo_q : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed cases from the test plan, then random traffic,
// all checked every cycle against an arithmetic model of HI/LO and the busy window.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.DATA_W(W)) bus();
  mdu_sequencer #(.DATA_W(W), .CNT_W(6)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      6'd24: return sa * sb;
      6'd25: return ua * ub;
      6'd26, 6'd27: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (f == 6'd26) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit is_mdu(input logic [5:0] f);
    return (f >= 6'd16 && f <= 6'd19) || (f >= 6'd24 && f <= 6'd27);
  endfunction

  // Model: remaining busy cycles and the result that lands when they run out.
  int          m_busy = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy > 0) begin
        if (bus.i_con_Abort) m_busy = 0;
        else begin
          m_busy--;
          if (m_busy == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (bus.i_con_Start && !bus.i_con_Abort) begin
        if (bus.i_con_FuncCode == 6'd17) m_hi = bus.i_dat_Rs;
        else if (bus.i_con_FuncCode == 6'd19) m_lo = bus.i_dat_Rs;
        else if (bus.i_con_FuncCode >= 6'd24 && bus.i_con_FuncCode <= 6'd27) begin
          {p_hi, p_lo} = mdu_ref(bus.i_con_FuncCode, bus.i_dat_Rs, bus.i_dat_Rt);
          m_busy = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.o_con_Busy, m_busy > 0);
      check("done", bus.o_con_Done, m_done);
      check("hi", bus.o_dat_Hi, m_hi);
      check("lo", bus.o_dat_Lo, m_lo);
      check("stall", bus.o_con_Stall,
            (m_busy > 0) && bus.i_con_Start && is_mdu(bus.i_con_FuncCode));
      check("mfdata", bus.o_dat_MfData,
            (bus.i_con_FuncCode == 6'd16) ? m_hi :
            (bus.i_con_FuncCode == 6'd18) ? m_lo : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.i_con_Start    = 1'b1;
    bus.i_con_FuncCode = f;
    bus.i_dat_Rs       = a;
    bus.i_dat_Rt       = b;
    step();
    bus.i_con_Start    = 1'b0;
    bus.i_con_FuncCode = 6'd0;
  endtask

  // Counts busy cycles and Done pulses until one cycle after Busy falls.
  task automatic run_count(output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_con_Done) dc++;
      if (!bus.o_con_Busy) break;
      bc++;
      step();
    end
    step();
    if (bus.o_con_Done) dc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [5:0] codes [10] = '{6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27, 6'd0, 6'd32};

  initial begin
    int bc, dc;
    bus.i_con_Start = 1'b0; bus.i_con_FuncCode = 6'd0; bus.i_con_Abort = 1'b0;
    bus.i_dat_Rs = '0; bus.i_dat_Rt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", bus.o_con_Busy, 0);
    check("rst_hi", bus.o_dat_Hi, 0);
    check("rst_lo", bus.o_dat_Lo, 0);
    check("rst_done", bus.o_con_Done, 0);
    rst = 1'b0;
    step();

    issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_count(bc, dc);
    check("multu_busy_len", bc, 33);
    check("multu_done_cnt", dc, 1);
    check("multu_hi", bus.o_dat_Hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.o_dat_Lo, 32'h0000_0001);

    issue(6'd24, 32'hFFFF_FFFD, 32'h0000_0005);
    run_count(bc, dc);
    check("mult_hi", bus.o_dat_Hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.o_dat_Lo, 32'hFFFF_FFF1);
    bus.i_con_Start = 1'b1; bus.i_con_FuncCode = 6'd16;
    #1;
    check("mfhi_data", bus.o_dat_MfData, 32'hFFFF_FFFF);
    step();
    bus.i_con_Start = 1'b0; bus.i_con_FuncCode = 6'd0;

    issue(6'd26, 32'hFFFF_FFF9, 32'h0000_0002);
    run_count(bc, dc);
    check("div_lo", bus.o_dat_Lo, 32'hFFFF_FFFD);
    check("div_hi", bus.o_dat_Hi, 32'hFFFF_FFFF);
    issue(6'd27, 32'd100, 32'd0);
    run_count(bc, dc);
    check("divu0_busy_len", bc, 33);
    check("divu0_lo", bus.o_dat_Lo, 32'hFFFF_FFFF);
    check("divu0_hi", bus.o_dat_Hi, 32'h0000_0064);

    issue(6'd17, 32'h1234_5678, 32'h0);
    check("mthi_hi", bus.o_dat_Hi, 32'h1234_5678);
    issue(6'd24, 32'd3, 32'd4);
    repeat (4) step();
    bus.i_con_Start = 1'b1; bus.i_con_FuncCode = 6'd18;
    #1;
    check("mflo_stall", bus.o_con_Stall, 1);
    check("hi_held", bus.o_dat_Hi, 32'h1234_5678);
    step();
    bus.i_con_Start = 1'b0; bus.i_con_FuncCode = 6'd0;
    run_count(bc, dc);
    check("mult34_hi", bus.o_dat_Hi, 32'h0);
    check("mult34_lo", bus.o_dat_Lo, 32'hC);

    issue(6'd25, 32'd7, 32'd9);
    repeat (9) step();
    bus.i_con_Abort = 1'b1; bus.i_con_Start = 1'b1; bus.i_con_FuncCode = 6'd25;
    bus.i_dat_Rs = 32'd11; bus.i_dat_Rt = 32'd13;
    step();
    bus.i_con_Abort = 1'b0; bus.i_con_Start = 1'b0; bus.i_con_FuncCode = 6'd0;
    check("abort_busy", bus.o_con_Busy, 0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_con_Done || bus.o_con_Busy) dc++;
      step();
    end
    check("abort_no_done", dc, 0);
    check("abort_hi", bus.o_dat_Hi, 32'h0);
    check("abort_lo", bus.o_dat_Lo, 32'hC);

    issue(6'd26, 32'd1000, 32'd7);
    repeat (19) step();
    rst = 1'b1;
    #2;
    check("mid_rst_busy", bus.o_con_Busy, 0);
    check("mid_rst_hi", bus.o_dat_Hi, 0);
    check("mid_rst_lo", bus.o_dat_Lo, 0);
    check("mid_rst_done", bus.o_con_Done, 0);
    step();
    rst = 1'b0;
    issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    run_count(bc, dc);
    check("ovf_lo", bus.o_dat_Lo, 32'h8000_0000);
    check("ovf_hi", bus.o_dat_Hi, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      bus.i_con_Start    = ($urandom_range(0, 1) == 0);
      bus.i_con_FuncCode = codes[$urandom_range(0, 9)];
      bus.i_con_Abort    = ($urandom_range(0, 39) == 0);
      bus.i_dat_Rs       = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       bus.i_dat_Rt = 32'h0;
        1:       bus.i_dat_Rt = 32'hFFFF_FFFF;
        2:       bus.i_dat_Rt = $urandom_range(1, 9);
        default: bus.i_dat_Rt = $urandom;
      endcase
      step();
    end
    bus.i_con_Start = 1'b0; bus.i_con_Abort = 1'b0; bus.i_con_FuncCode = 6'd0;
    repeat (40) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
- Executes R-type funct codes that the single-cycle ALU cannot complete in one cycle: mult, multu, div, divu. Also handles the single-cycle ops mthi, mtlo, mfhi and mflo.
- Sits beside the ALU in the EX stage. Raises o_con_Stall so the pipeline holds while an iterative operation is in flight.

Parameters:
- DATA_W, 32, operand, HI and LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_con_Start  in  1  EX stage holds a valid MDU instruction this cycle.
- i_con_FuncCode  in  6  funct field: 16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu.
- i_con_Abort  in  1  pipeline flush; kills any in-flight operation.
- i_dat_Rs  in  DATA_W  rs operand: multiplicand/dividend, or mthi/mtlo source.
- i_dat_Rt  in  DATA_W  rt operand: multiplier/divisor.
- o_con_Busy  out  1  high while state is not IDLE.
- o_con_Stall  out  1  combinational: o_con_Busy & i_con_Start & funct is any code listed above.
- o_con_Done  out  1  one-cycle pulse when HI/LO receive an iterative result.
- o_dat_Hi  out  DATA_W  HI register.
- o_dat_Lo  out  DATA_W  LO register.
- o_dat_MfData  out  DATA_W  combinational: HI if funct=16, LO if funct=18, else 0.

Behaviour:
- Reset (async, any state): state=IDLE, HI=0, LO=0, counter=0, all internal operands=0, o_con_Busy=0, o_con_Done=0.
- States:
  - IDLE -> RUN on an accepted mult/multu/div/divu.
  - RUN -> FIX when the counter reaches DATA_W-1.
  - FIX -> IDLE unconditionally.
- Accept rule: i_con_Start=1, state=IDLE, funct in {24,25,26,27}. On that edge:
  - Latch the operands.
  - For signed ops (24, 26), latch operand magnitudes and sign flags.
  - Clear the counter.
- mthi/mtlo (17/19) in IDLE: HI (or LO) <= i_dat_Rs at the same edge; no state change; no Done pulse.
- mfhi/mflo (16/18): no state change; data read via o_dat_MfData.
- Any other funct: ignored.
- Any Start while Busy: ignored, and o_con_Stall is asserted. The pipeline re-presents the instruction after Busy falls.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2*DATA_W-bit accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle.
- Counter increments once per RUN cycle; RUN lasts exactly DATA_W cycles.
- FIX (one cycle): apply sign correction and write HI/LO on the FIX->IDLE edge. o_con_Done is registered high in the following cycle only.
- Sign rules:
  - mult: 64-bit product negated when the operand signs differ.
  - div: quotient negated when the signs differ; remainder takes the sign of the dividend.
  - multu/divu: no correction.
- Latency: Busy is high for DATA_W+1 cycles after the accept edge. The new HI/LO are visible in the first cycle Busy is low, which is the same cycle as Done.
- Divide by zero: no trap and same latency. Result is LO=all-ones and HI=the original rs value, for both div and divu. No sign correction for signed div by zero.
- Signed overflow (div, 0x80000000 / -1): LO=0x80000000, HI=0.
- Abort:
  - In RUN or FIX: state=IDLE on the next edge; HI/LO unchanged; no Done pulse.
  - Abort takes priority over the FIX write and over Start in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; the partial result is discarded.

Test Plan:
- Reset, then multu 0xFFFFFFFF x 0xFFFFFFFF -> Busy high for 33 cycles; Done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- mult -3 x 5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfhi then returns 0xFFFFFFFF on o_dat_MfData.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 100/0 -> LO=0xFFFFFFFF, HI=0x00000064.
- mthi 0x12345678, then mult started and mflo presented at RUN cycle 5 -> o_con_Stall=1; HI stays 0x12345678 until the FIX edge.
- Abort at RUN cycle 10 -> Busy=0 next cycle; HI/LO unchanged; Done never pulses. A Start on the same cycle as Abort is not accepted.
- Assert i_rst at RUN cycle 20 -> Busy, HI, LO and Done read 0 before the next clock edge; a subsequent div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
